ov7670_pixel_capture: RTL and testbench

- Upstream neighbour of the Sobel convolution stage, running in the camera PCLK domain.
- Decodes OV7670 VSYNC/HREF timing and pairs byte pairs into RGB565 pixels.
- Writes 17-bit words `{sof, rgb565}` into the camera async FIFO that the Sobel stage drains.
- Enforces frame geometry, drops whole frames on FIFO overflow and reports status.

---
 rtl/ov7670_pixel_capture.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ov7670_pixel_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_pixel_capture.sv
// OV7670 capture front end: decodes VSYNC/HREF, pairs bytes into RGB565 and writes {sof, pixel} words to the camera FIFO.
// Build macro TEST_PATTERN_EN adds a test_mode input that substitutes an 8-bar colour pattern for camera data.
module ov7670_pixel_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int LINE_W   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  pixel_data,
    input  logic        capture_en,
    input  logic        clear,
    input  logic        fifo_full,
`ifdef TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        wr_en,
    output logic [16:0] wr_data,
    output logic        frame_done,
    output logic        overflow,
    output logic        sync_err,
    output logic [7:0]  frame_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [LINE_W-1:0] H_LIM = LINE_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] V_LIM = LINE_W'(V_ACTIVE);

    // input register stage and one-cycle history for edge detection
    logic        vsync_r;
    logic        href_r;
    logic [7:0]  data_r;
    logic        vsync_d_r;
    logic        href_d_r;

    // byte pairing stage
    logic        phase_r;
    logic [7:0]  hi_r;
    logic        pix_valid_r;
    logic [15:0] pix_r;
    logic        line_end_r;
    logic        line_odd_r;
    logic        vs_rise_r;
    logic        vs_fall_r;
    logic        href_rise_s;
    logic        href_fall_s;
    logic        byte_phase_s;

    // frame control stage
    state_t            state_r;
    state_t            state_s;
    logic [LINE_W-1:0] line_cnt_r;
    logic [LINE_W-1:0] line_cnt_s;
    logic [LINE_W-1:0] pix_cnt_r;
    logic [LINE_W-1:0] pix_cnt_s;
    logic              sof_pending_r;
    logic              sof_pending_s;
    logic              from_drop_r;
    logic              from_drop_s;
    logic              in_range_s;
    logic              start_s;
    logic              wr_en_s;
    logic [16:0]       wr_data_s;
    logic              frame_done_s;
    logic              ovf_set_s;
    logic              serr_set_s;
    logic [7:0]        frame_count_s;
    logic [15:0]       pix_value_s;

`ifdef TEST_PATTERN_EN
    logic              test_mode_r;

    function automatic logic [15:0] bar_colour(input logic [LINE_W-1:0] col);
        logic [LINE_W-1:0] bar;
        bar = col / LINE_W'(H_ACTIVE / 8);
        case (bar)
            LINE_W'(0): bar_colour = 16'hFFFF;
            LINE_W'(1): bar_colour = 16'hFFE0;
            LINE_W'(2): bar_colour = 16'h07FF;
            LINE_W'(3): bar_colour = 16'h07E0;
            LINE_W'(4): bar_colour = 16'hF81F;
            LINE_W'(5): bar_colour = 16'hF800;
            LINE_W'(6): bar_colour = 16'h001F;
            default:    bar_colour = 16'h0000;
        endcase
    endfunction
`endif

    // Register the raw camera inputs and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r   <= 1'b0;
            href_r    <= 1'b0;
            data_r    <= 8'h00;
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            vsync_r   <= vsync;
            href_r    <= href;
            data_r    <= pixel_data;
            vsync_d_r <= vsync_r;
            href_d_r  <= href_r;
        end
    end

    // Edge detection and the phase of the byte currently in data_r
    always_comb begin
        href_rise_s  = href_r & ~href_d_r;
        href_fall_s  = ~href_r & href_d_r;
        byte_phase_s = href_rise_s ? 1'b0 : phase_r;
    end

    // Pair hi/lo bytes; line and frame events travel alongside the pixel stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r     <= 1'b0;
            hi_r        <= 8'h00;
            pix_valid_r <= 1'b0;
            pix_r       <= 16'h0000;
            line_end_r  <= 1'b0;
            line_odd_r  <= 1'b0;
            vs_rise_r   <= 1'b0;
            vs_fall_r   <= 1'b0;
        end else begin
            phase_r     <= href_r ? ~byte_phase_s : phase_r;
            hi_r        <= (href_r && !byte_phase_s) ? data_r : hi_r;
            pix_valid_r <= href_r & byte_phase_s;
            pix_r       <= {hi_r, data_r};
            line_end_r  <= href_fall_s;
            // phase_r still reflects the last byte of the line: 1 means a hi byte was left unpaired
            line_odd_r  <= href_fall_s & phase_r;
            vs_rise_r   <= vsync_r & ~vsync_d_r;
            vs_fall_r   <= ~vsync_r & vsync_d_r;
        end
    end

    // Select camera data or the bar pattern for the pixel being written
    always_comb begin
        pix_value_s = pix_r;
`ifdef TEST_PATTERN_EN
        if (test_mode_r) begin
            pix_value_s = bar_colour(pix_cnt_r);
        end else begin
            pix_value_s = pix_r;
        end
`endif
    end

    // Frame FSM next-state, counters and output decisions
    always_comb begin
        state_s       = state_r;
        line_cnt_s    = line_cnt_r;
        pix_cnt_s     = pix_cnt_r;
        sof_pending_s = sof_pending_r;
        from_drop_s   = from_drop_r;
        wr_en_s       = 1'b0;
        wr_data_s     = wr_data;
        frame_done_s  = 1'b0;
        ovf_set_s     = 1'b0;
        serr_set_s    = 1'b0;
        frame_count_s = frame_count;
        in_range_s    = (pix_cnt_r < H_LIM) && (line_cnt_r < V_LIM);
        start_s       = (state_r == IDLE) && vs_fall_r && capture_en;

        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s       = CAPTURE;
                    line_cnt_s    = {LINE_W{1'b0}};
                    pix_cnt_s     = {LINE_W{1'b0}};
                    sof_pending_s = 1'b1;
                    from_drop_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            CAPTURE: begin
                if (pix_valid_r && in_range_s) begin
                    if (fifo_full) begin
                        state_s     = DROP;
                        from_drop_s = 1'b1;
                        ovf_set_s   = 1'b1;
                    end else begin
                        wr_en_s       = 1'b1;
                        wr_data_s     = {sof_pending_r, pix_value_s};
                        sof_pending_s = 1'b0;
                        pix_cnt_s     = pix_cnt_r + LINE_W'(1);
                    end
                end else begin
                    pix_cnt_s = pix_cnt_r;
                end
                if (line_end_r) begin
                    pix_cnt_s  = {LINE_W{1'b0}};
                    line_cnt_s = (line_cnt_r < V_LIM) ? line_cnt_r + LINE_W'(1) : line_cnt_r;
                    serr_set_s = line_odd_r;
                end else begin
                    line_cnt_s = line_cnt_r;
                end
                state_s = vs_rise_r ? DONE : state_s;
            end
            DROP: begin
                state_s = vs_rise_r ? DONE : DROP;
            end
            DONE: begin
                frame_done_s = 1'b1;
                state_s      = IDLE;
                if (!from_drop_r) begin
                    if (line_cnt_r == V_LIM) begin
                        frame_count_s = frame_count + 8'd1;
                    end else begin
                        serr_set_s = 1'b1;
                    end
                end else begin
                    frame_count_s = frame_count;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Frame state, counters and registered outputs; a flag set beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            line_cnt_r    <= {LINE_W{1'b0}};
            pix_cnt_r     <= {LINE_W{1'b0}};
            sof_pending_r <= 1'b0;
            from_drop_r   <= 1'b0;
            wr_en         <= 1'b0;
            wr_data       <= 17'h00000;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            sync_err      <= 1'b0;
            frame_count   <= 8'h00;
        end else begin
            state_r       <= state_s;
            line_cnt_r    <= line_cnt_s;
            pix_cnt_r     <= pix_cnt_s;
            sof_pending_r <= sof_pending_s;
            from_drop_r   <= from_drop_s;
            wr_en         <= wr_en_s;
            wr_data       <= wr_data_s;
            frame_done    <= frame_done_s;
            overflow      <= ovf_set_s | (overflow & ~clear);
            sync_err      <= serr_set_s | (sync_err & ~clear);
            frame_count   <= frame_count_s;
        end
    end

`ifdef TEST_PATTERN_EN
    // Latch the pattern selection once per frame at capture start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test_mode_r <= 1'b0;
        end else begin
            test_mode_r <= start_s ? test_mode : test_mode_r;
        end
    end
`endif

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Bench for ov7670_pixel_capture on a reduced 16x6 geometry: table of frame scenarios,
// random frames against a byte-level reference model, reset-abort and frame_count wrap sequences.
module tb_ov7670_pixel_capture;
    localparam int H     = 16;
    localparam int V     = 6;
    localparam int NEVER = 1 << 30;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        vsync      = 1'b1;
    logic        href       = 1'b0;
    logic [7:0]  pixel_data = 8'h00;
    logic        capture_en = 1'b1;
    logic        clear      = 1'b0;
    logic        fifo_full  = 1'b0;
    logic        wr_en;
    logic [16:0] wr_data;
    logic        frame_done;
    logic        overflow;
    logic        sync_err;
    logic [7:0]  frame_count;

    ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .href       (href),
        .pixel_data (pixel_data),
        .capture_en (capture_en),
        .clear      (clear),
        .fifo_full  (fifo_full),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .overflow   (overflow),
        .sync_err   (sync_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nlines;
        int nbytes;
        int odd_line;
        int full_at;
        bit cap_en;
        bit clr;
        bit fixed;
        int exp_wr;
        bit exp_ovf;
        bit exp_serr;
        int exp_fc;
    } vec_t;

    vec_t        tv[8];
    int          ntests   = 0;
    int          nfail    = 0;
    int          cyc      = 0;
    int          total_wr = 0;
    int          done_cnt = 0;
    logic [16:0] wr_log[$];
    int          wr_cyc_log[$];

    int          frame_base = 0;
    int          done_base  = 0;
    int          full_at    = NEVER;
    logic [16:0] exp_q[$];
    int          lo_cyc_q[$];
    logic [7:0]  m_fc   = 8'h00;
    logic        m_ovf  = 1'b0;
    logic        m_serr = 1'b0;
    int          exp_done = 0;
    bit          aborted  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_log.push_back(wr_data);
            wr_cyc_log.push_back(cyc);
            total_wr <= total_wr + 1;
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        fifo_full = ((total_wr - frame_base) >= full_at);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("reset.outputs", 32'({wr_en, wr_data, frame_done, overflow, sync_err, frame_count}), 32'd0);
        exp_q.delete();
        lo_cyc_q.delete();
        exp_done = 0;
        aborted  = 1'b1;
        m_fc     = 8'h00;
        m_ovf    = 1'b0;
        m_serr   = 1'b0;
        tick();
        rst_n      = 1'b1;
        frame_base = total_wr;
        done_base  = done_cnt;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        m_ovf  = 1'b0;
        m_serr = 1'b0;
        tick();
        tick();
        chk("clear.flags", 32'({overflow, sync_err}), 32'd0);
    endtask

    // drives one frame and builds the expected write list from the pixel/line/frame rules
    task automatic send_frame(input int nlines, input int nbytes, input int odd_line,
                              input bit fixed, input int rst_at);
        int         nw;
        int         len;
        int         bidx;
        logic       sof;
        bit         dropped;
        logic [7:0] hi;
        logic [7:0] b;
        frame_base = total_wr;
        done_base  = done_cnt;
        exp_q.delete();
        lo_cyc_q.delete();
        nw       = 0;
        sof      = 1'b1;
        dropped  = 1'b0;
        aborted  = 1'b0;
        bidx     = 0;
        hi       = 8'h00;
        exp_done = capture_en ? 1 : 0;
        vsync = 1'b1;
        href  = 1'b0;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            len = nbytes + ((l == odd_line) ? 1 : 0);
            for (int i = 0; i < len; i++) begin
                if (bidx == rst_at) reset_pulse();
                b = fixed ? ((i % 2 == 0) ? 8'hF8 : 8'h1F) : 8'($urandom);
                href       = 1'b1;
                pixel_data = b;
                if (i % 2 == 0) begin
                    hi = b;
                end else if (capture_en && !aborted && !dropped && l < V && i / 2 < H) begin
                    if (nw == full_at) begin
                        dropped = 1'b1;
                        m_ovf   = 1'b1;
                    end else begin
                        exp_q.push_back({sof, hi, b});
                        lo_cyc_q.push_back(cyc + 1);
                        sof = 1'b0;
                        nw++;
                    end
                end
                bidx++;
                tick();
            end
            if ((len % 2 == 1) && capture_en && !aborted && !dropped) m_serr = 1'b1;
            href = 1'b0;
            repeat (3) tick();
        end
        repeat (2) tick();
        vsync = 1'b1;
        repeat (8) tick();
        if (capture_en && !aborted && !dropped) begin
            if (nlines >= V) m_fc = m_fc + 8'd1;
            else m_serr = 1'b1;
        end
        full_at   = NEVER;
        fifo_full = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        int nw_act;
        nw_act = total_wr - frame_base;
        chk({tag, ".writes"}, 32'(nw_act), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < nw_act; i++) begin
            chk({tag, ".data"}, 32'(wr_log[frame_base + i]), 32'(exp_q[i]));
            chk({tag, ".latency"}, 32'(wr_cyc_log[frame_base + i]), 32'(lo_cyc_q[i] + 2));
        end
        chk({tag, ".frame_done"}, 32'(done_cnt - done_base), 32'(exp_done));
        chk({tag, ".frame_count"}, 32'(frame_count), 32'(m_fc));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_serr));
    endtask

    initial begin
        int         nl;
        int         nb;
        int         ol;
        logic [7:0] fc_start;
        tv[0] = '{6, 32, -1, NEVER, 1'b1, 1'b0, 1'b1, 96, 1'b0, 1'b0, 1};
        tv[1] = '{6, 32, -1, 10,    1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1};
        tv[2] = '{6, 32, -1, NEVER, 1'b1, 1'b1, 1'b0, 96, 1'b0, 1'b0, 2};
        tv[3] = '{6, 32,  2, NEVER, 1'b1, 1'b0, 1'b0, 96, 1'b0, 1'b1, 3};
        tv[4] = '{5, 32, -1, NEVER, 1'b1, 1'b1, 1'b0, 80, 1'b0, 1'b1, 3};
        tv[5] = '{7, 40, -1, NEVER, 1'b1, 1'b1, 1'b0, 96, 1'b0, 1'b0, 4};
        tv[6] = '{6, 32, -1, NEVER, 1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0, 4};
        tv[7] = '{6, 20, -1, NEVER, 1'b1, 1'b0, 1'b0, 60, 1'b0, 1'b0, 5};

        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset.state", 32'({wr_en, wr_data, frame_done, overflow, sync_err, frame_count}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int t = 0; t < 8; t++) begin
            if (tv[t].clr) pulse_clear();
            capture_en = tv[t].cap_en;
            full_at    = tv[t].full_at;
            send_frame(tv[t].nlines, tv[t].nbytes, tv[t].odd_line, tv[t].fixed, -1);
            check_frame($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d.exp_writes", t), 32'(total_wr - frame_base), 32'(tv[t].exp_wr));
            chk($sformatf("tbl%0d.exp_overflow", t), 32'(overflow), 32'(tv[t].exp_ovf));
            chk($sformatf("tbl%0d.exp_sync_err", t), 32'(sync_err), 32'(tv[t].exp_serr));
            chk($sformatf("tbl%0d.exp_frame_count", t), 32'(frame_count), 32'(tv[t].exp_fc));
            if (t == 0) begin
                chk("tbl0.first_word", 32'(wr_log[frame_base]), 32'h1F81F);
                chk("tbl0.last_word", 32'(wr_log[total_wr - 1]), 32'h0F81F);
            end
        end
        capture_en = 1'b1;

        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 3) == 0) pulse_clear();
            nl = $urandom_range(4, 8);
            nb = 2 * $urandom_range(8, 20);
            ol = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
            full_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 100) : NEVER;
            send_frame(nl, nb, ol, 1'b0, -1);
            check_frame($sformatf("rnd%0d", r));
        end

        send_frame(6, 32, -1, 1'b0, 40);
        check_frame("rst_abort");
        send_frame(6, 32, -1, 1'b0, -1);
        check_frame("rst_next");
        chk("rst_next.sof", 32'(wr_log[frame_base][16]), 32'd1);

        fc_start = frame_count;
        for (int f = 0; f < 256; f++) begin
            send_frame(6, 2, -1, 1'b0, -1);
            check_frame($sformatf("wrap%0d", f));
        end
        chk("wrap.frame_count", 32'(frame_count), 32'(fc_start));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
